// File: rtl/bp_stream_pump_in_pkg.sv
// Shared types for the inbound stream pump: memory message header, message/size
// encodings, payload mask helpers and the stream FSM state.
package bp_stream_pump_in_pkg;

  localparam int paddr_width_gp     = 40;
  localparam int lce_id_width_gp    = 8;
  localparam int dword_width_gp     = 64;
  localparam int cce_block_width_gp = 512;
  localparam int msg_types_gp       = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } mem_msg_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } msg_size_e;

  typedef struct packed {
    mem_msg_type_e               msg_type;
    logic [lce_id_width_gp-1:0]  lce_id;
    logic [paddr_width_gp-1:0]   addr;
    msg_size_e                   size;
  } mem_msg_header_s;

  // One bit per message type; set means that type carries a data payload.
  localparam logic [msg_types_gp-1:0] e_payload_mem_wr_mask    = msg_types_gp'(1) << e_bedrock_mem_wr;
  localparam logic [msg_types_gp-1:0] e_payload_mem_uc_wr_mask = msg_types_gp'(1) << e_bedrock_mem_uc_wr;
  localparam logic [msg_types_gp-1:0] e_payload_mem_amo_mask   = msg_types_gp'(1) << e_bedrock_mem_amo;

  function automatic logic has_payload(input logic [msg_types_gp-1:0] mask,
                                       input mem_msg_type_e msg_type);
    return mask[msg_type];
  endfunction

  typedef enum logic {
    e_ready  = 1'b0,
    e_stream = 1'b1
  } stream_state_e;

endpackage

// File: rtl/bp_stream_pump_in.sv
// Inbound stream pump: presents multi-beat bus messages to an FSM beat by beat with a
// stable base header, and expands data-less multi-beat commands into N FSM beats.
module bp_stream_pump_in
  import bp_stream_pump_in_pkg::*;
#(
  parameter int                       stream_data_width_p = dword_width_gp,
  parameter int                       block_width_p       = cce_block_width_gp,
  parameter logic [msg_types_gp-1:0]  payload_mask_p      = '0,
  localparam int stream_words_lp        = block_width_p / stream_data_width_p,
  localparam int data_len_width_lp      = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1,
  localparam int stream_offset_width_lp = ((stream_data_width_p / 8) > 1) ? $clog2(stream_data_width_p / 8) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  mem_msg_header_s                mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  output logic                           mem_yumi_o,

  output mem_msg_header_s                fsm_base_header_o,
  output logic [paddr_width_gp-1:0]      fsm_addr_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_yumi_i,
  output logic [data_len_width_lp-1:0]   cnt_o,
  output logic                           done_o
);

  stream_state_e                 r_state, w_state_n;
  mem_msg_header_s               r_header, w_base_header;
  logic [data_len_width_lp-1:0]  r_cnt, w_cnt, w_first_cnt, w_last_cnt;
  logic [7:0]                    w_size_bytes, w_num_stream;
  logic                          w_multi, w_has_data, w_last;
  logic                          w_cnt_set, w_cnt_inc, w_hdr_en;
  logic [paddr_width_gp-1:0]     w_exp_addr;

  // The first beat of a message is still on the bus in e_ready, so classify on it directly.
  assign w_base_header = (r_state == e_ready) ? mem_header_i : r_header;
  assign w_has_data    = has_payload(payload_mask_p, w_base_header.msg_type);

  assign w_size_bytes = 8'(1) << w_base_header.size;
  assign w_num_stream = w_size_bytes >> stream_offset_width_lp;
  assign w_multi      = (w_num_stream > 8'd1);

  assign w_first_cnt = w_base_header.addr[stream_offset_width_lp +: data_len_width_lp];
  // Truncation to the counter width gives critical-word-first wraparound inside the block.
  assign w_last_cnt  = w_first_cnt + w_num_stream[data_len_width_lp-1:0] - data_len_width_lp'(1);
  assign w_cnt       = (r_state == e_ready) ? w_first_cnt : r_cnt;
  assign w_last      = (w_cnt == w_last_cnt);

  always_comb begin
    w_exp_addr = w_base_header.addr;
    w_exp_addr[stream_offset_width_lp +: data_len_width_lp] = w_cnt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_n  = r_state;
    fsm_v_o    = 1'b0;
    mem_yumi_o = 1'b0;
    done_o     = 1'b0;
    cnt_o      = '0;
    w_cnt_set  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_hdr_en   = 1'b0;
    if (reset_n_i) begin
      fsm_v_o = mem_v_i;
      cnt_o   = w_cnt;
      if (!w_multi) begin
        mem_yumi_o = fsm_yumi_i;
        done_o     = fsm_yumi_i;
      end else begin
        done_o     = fsm_yumi_i & w_last;
        // Data-less commands hold their single bus beat until the final expanded beat.
        mem_yumi_o = w_has_data ? fsm_yumi_i : done_o;
        if (r_state == e_ready) begin
          if (fsm_yumi_i) begin
            w_hdr_en  = 1'b1;
            w_cnt_set = 1'b1;
            if (!w_last) w_state_n = e_stream;
          end
        end else begin
          w_cnt_inc = fsm_yumi_i;
          if (done_o) w_state_n = e_ready;
        end
      end
    end
  end

  assign fsm_base_header_o = w_base_header;
  assign fsm_addr_o        = (w_multi && !w_has_data) ? w_exp_addr : mem_header_i.addr;
  assign fsm_data_o        = mem_data_i;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: the header register is reset along with the control state so the base header is never X.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= e_ready;
      r_cnt    <= '0;
      r_header <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_cnt_set)      r_cnt <= w_first_cnt + data_len_width_lp'(1);
      else if (w_cnt_inc) r_cnt <= r_cnt + data_len_width_lp'(1);
      if (w_hdr_en)       r_header <= mem_header_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(fsm_yumi_i && !fsm_v_o));
    end
  end

endmodule

// File: tb/tb_bp_stream_pump_in.sv
// Self-checking bench for bp_stream_pump_in: directed scenarios plus random messages,
// checked against a per-message beat list built from the message rules.
module tb_bp_stream_pump_in;
  import bp_stream_pump_in_pkg::*;

  localparam logic [msg_types_gp-1:0] mask_lp = e_payload_mem_wr_mask | e_payload_mem_uc_wr_mask;

  logic                      clk_i = 1'b0;
  logic                      reset_n_i;
  mem_msg_header_s           mem_header_i;
  logic [63:0]               mem_data_i;
  logic                      mem_v_i;
  logic                      mem_yumi_o;
  mem_msg_header_s           fsm_base_header_o;
  logic [paddr_width_gp-1:0] fsm_addr_o;
  logic [63:0]               fsm_data_o;
  logic                      fsm_v_o;
  logic                      fsm_yumi_i;
  logic [2:0]                cnt_o;
  logic                      done_o;

  bp_stream_pump_in #(
    .stream_data_width_p(64),
    .block_width_p      (512),
    .payload_mask_p     (mask_lp)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .mem_header_i     (mem_header_i),
    .mem_data_i       (mem_data_i),
    .mem_v_i          (mem_v_i),
    .mem_yumi_o       (mem_yumi_o),
    .fsm_base_header_o(fsm_base_header_o),
    .fsm_addr_o       (fsm_addr_o),
    .fsm_data_o       (fsm_data_o),
    .fsm_v_o          (fsm_v_o),
    .fsm_yumi_i       (fsm_yumi_i),
    .cnt_o            (cnt_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    mem_msg_header_s hdr;
    logic [63:0]     data;
  } bus_beat_t;

  typedef struct {
    logic [paddr_width_gp-1:0] addr;
    int                        cnt;
    logic [63:0]               data;
    bit                        chk_data;
    bit                        done;
    bit                        yumi;
    mem_msg_header_s           base;
  } fsm_beat_t;

  bus_beat_t bus_q[$];
  fsm_beat_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Builds the bus beats for one message and the FSM beats it must produce.
  task automatic add_msg(input mem_msg_type_e t, input msg_size_e s, input logic [paddr_width_gp-1:0] addr);
    int num, first, c;
    bit has_data;
    mem_msg_header_s hdr, h;
    logic [paddr_width_gp-1:0] a, block_base;
    logic [63:0] d;
    bus_beat_t bb;
    fsm_beat_t fb;
    num = (1 << int'(s)) / 8;
    if (num < 1) num = 1;
    first = int'((addr / 8) % 8);
    has_data = mask_lp[t];
    block_base = addr & ~paddr_width_gp'(64'h3F);
    hdr = '{msg_type: t, lce_id: 8'($urandom), addr: addr, size: s};
    if (num == 1) begin
      d = {$urandom, $urandom};
      bb = '{hdr: hdr, data: d};
      bus_q.push_back(bb);
      fb = '{addr: addr, cnt: first, data: d, chk_data: 1'b1, done: 1'b1, yumi: 1'b1, base: hdr};
      exp_q.push_back(fb);
    end else if (has_data) begin
      for (int i = 0; i < num; i++) begin
        c = (first + i) % 8;
        a = block_base + paddr_width_gp'(c * 8) + (addr & paddr_width_gp'(7));
        h = hdr;
        h.addr = a;
        d = {$urandom, $urandom};
        bb = '{hdr: h, data: d};
        bus_q.push_back(bb);
        fb = '{addr: a, cnt: c, data: d, chk_data: 1'b1, done: (i == num - 1), yumi: 1'b1, base: hdr};
        exp_q.push_back(fb);
      end
    end else begin
      d = {$urandom, $urandom};
      bb = '{hdr: hdr, data: d};
      bus_q.push_back(bb);
      for (int i = 0; i < num; i++) begin
        c = (first + i) % 8;
        a = block_base + paddr_width_gp'(c * 8) + (addr & paddr_width_gp'(7));
        fb = '{addr: a, cnt: c, data: '0, chk_data: 1'b0, done: (i == num - 1), yumi: (i == num - 1), base: hdr};
        exp_q.push_back(fb);
      end
    end
  endtask

  // Drives queued bus beats and FSM acceptance; entered and left at posedge+1.
  task automatic run_msgs(input int stop_after, input int gap_pct, input int yumi_pct, output int cycles);
    int accepted = 0;
    int exp_dones = 0;
    int seen_dones = 0;
    bit have = 1'b0;
    bus_beat_t cur;
    fsm_beat_t e;
    cycles = 0;
    foreach (exp_q[i]) if (exp_q[i].done) exp_dones++;
    while ((bus_q.size() > 0 || have) && (stop_after < 0 || accepted < stop_after)) begin
      if (cycles > 4000) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
      if (!have && bus_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        cur = bus_q.pop_front();
        have = 1'b1;
      end
      mem_v_i = have;
      if (have) begin
        mem_header_i = cur.hdr;
        mem_data_i   = cur.data;
      end
      fsm_yumi_i = have && ($urandom_range(99) < yumi_pct);
      @(negedge clk_i);
      check("fsm_v", 64'(fsm_v_o), 64'(mem_v_i));
      if (have) begin
        if (exp_q.size() == 0) begin
          check("exp_underflow", 64'd1, 64'd0);
          break;
        end
        e = exp_q[0];
        check("fsm_addr", 64'(fsm_addr_o), 64'(e.addr));
        check("cnt", 64'(cnt_o), 64'(e.cnt));
        check("base_hdr", 64'(fsm_base_header_o), 64'(e.base));
        if (e.chk_data) check("fsm_data", fsm_data_o, e.data);
      end
      if (fsm_yumi_i) begin
        check("done", 64'(done_o), 64'(e.done));
        check("mem_yumi", 64'(mem_yumi_o), 64'(e.yumi));
        void'(exp_q.pop_front());
        accepted++;
        if (done_o) seen_dones++;
        if (mem_yumi_o) have = 1'b0;
      end else begin
        check("idle_done", 64'(done_o), 64'd0);
        check("idle_mem_yumi", 64'(mem_yumi_o), 64'd0);
      end
      @(posedge clk_i);
      #1;
      cycles++;
    end
    if (stop_after < 0) check("done_count", 64'(seen_dones), 64'(exp_dones));
    mem_v_i    = have;
    fsm_yumi_i = 1'b0;
  endtask

  initial begin
    int cyc;
    mem_msg_type_e t;
    reset_n_i    = 1'b0;
    mem_v_i      = 1'b1;
    mem_data_i   = 64'h0;
    fsm_yumi_i   = 1'b0;
    mem_header_i = '{msg_type: e_bedrock_mem_wr, lce_id: 8'h0, addr: 40'h1028, size: e_bedrock_msg_size_64};

    // Reset with a valid beat on the bus: all FSM-side outputs quiet.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_fsm_v", 64'(fsm_v_o), 64'd0);
    check("rst_mem_yumi", 64'(mem_yumi_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    mem_v_i   = 1'b0;
    @(negedge clk_i);
    check("idle_fsm_v", 64'(fsm_v_o), 64'd0);
    check("idle_first_cnt", 64'(cnt_o), 64'd5);
    @(posedge clk_i);
    #1;

    // Single uncached read passes straight through.
    add_msg(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h1008);
    run_msgs(-1, 0, 100, cyc);
    check("single_cycles", 64'(cyc), 64'd1);

    // Eight-beat write starting mid-block.
    add_msg(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h1010);
    run_msgs(-1, 0, 100, cyc);
    check("wr64_cycles", 64'(cyc), 64'd8);

    // Block read expanded from one bus beat.
    add_msg(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1038);
    run_msgs(-1, 0, 100, cyc);
    check("rd64_cycles", 64'(cyc), 64'd8);

    // 32B write with bus gaps and FSM backpressure.
    add_msg(e_bedrock_mem_wr, e_bedrock_msg_size_32, 40'h1020);
    run_msgs(-1, 40, 60, cyc);

    // Reset after the third beat of an eight-beat write.
    add_msg(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h1018);
    run_msgs(3, 0, 100, cyc);
    mem_header_i = bus_q[0].hdr;
    mem_data_i   = bus_q[0].data;
    mem_v_i      = 1'b1;
    reset_n_i    = 1'b0;
    bus_q.delete();
    exp_q.delete();
    repeat (2) begin
      @(negedge clk_i);
      check("midrst_fsm_v", 64'(fsm_v_o), 64'd0);
      check("midrst_done", 64'(done_o), 64'd0);
      check("midrst_cnt", 64'(cnt_o), 64'd0);
      check("midrst_mem_yumi", 64'(mem_yumi_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    reset_n_i = 1'b1;
    mem_v_i   = 1'b0;
    add_msg(e_bedrock_mem_wr, e_bedrock_msg_size_16, 40'h0);
    run_msgs(-1, 0, 100, cyc);
    check("post_rst_cycles", 64'(cyc), 64'd2);

    // Back-to-back single read then block write: no bubble between them.
    add_msg(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h2000);
    add_msg(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h2000);
    run_msgs(-1, 0, 100, cyc);
    check("b2b_cycles", 64'(cyc), 64'd9);

    // Random mix of message types, sizes and addresses.
    for (int m = 0; m < 30; m++) begin
      case ($urandom_range(3))
        0:       t = e_bedrock_mem_rd;
        1:       t = e_bedrock_mem_wr;
        2:       t = e_bedrock_mem_uc_rd;
        default: t = e_bedrock_mem_uc_wr;
      endcase
      add_msg(t, msg_size_e'($urandom_range(6)), 40'({$urandom_range(255), 8'($urandom)}));
    end
    run_msgs(-1, 30, 70, cyc);
    check("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
